memory_arb: RTL and testbench

Multi-port, single-storage word memory with byte-masked writes, a base-address decode, round-robin arbitration and a configurable pipelined read latency. It sits on the core's memory bus as the shared RAM slave, letting instruction-fetch and load/store masters, or extra masters such as DMA, share one array without external muxing. It replaces the single-port, zero-arbitration memory used by earlier cores.

---
 rtl/memory_pkg.sv | 31 +++
 rtl/memory_arb_rr_arbiter.sv | 43 ++++
 rtl/memory_arb.sv | 144 ++++++++++++++
 tb/tb_memory_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and helpers for the arbitrated word memory.
package memory_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MASK_W    = DATA_W / 8;
  localparam int unsigned MAX_PORTS = 4;
  localparam int unsigned PID_W     = $clog2(MAX_PORTS);

  // One read-pipeline stage: completion flag, owning port and captured word.
  typedef struct packed {
    logic              valid;
    logic [PID_W-1:0]  pid;
    logic [DATA_W-1:0] data;
  } rd_stage_t;

  // Word-index width for a given depth in words.
  function automatic int unsigned idx_width(input int unsigned words);
    return $clog2(words);
  endfunction

  // True when base <= addr < base + span; 33-bit math so a window ending at 4 GiB works.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [32:0] span);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + span));
  endfunction

endpackage

// File: rtl/memory_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, priority rotates past the winner.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant_c
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             hit;

  // Scan ranks from the pointer outward; the first requesting port wins.
  always_comb begin
    grant_c = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!hit && req[j] && (((j + int'(N) - int'(ptr)) % int'(N)) == i)) begin
          grant_c[j] = 1'b1;
          hit        = 1'b1;
          ptr_nxt    = PTR_W'((j + 1) % int'(N));
        end
      end
    end
  end

  // Pointer register, advanced only when something was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && hit) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/memory_arb.sv
// Shared word RAM slave: address decode, round-robin port arbitration,
// byte-masked writes and a READ_LATENCY-deep read pipeline.
module memory_arb
  import memory_pkg::*;
#(
  parameter int unsigned SIZE         = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned NPORTS       = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_F       = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NPORTS*DATA_W-1:0]   mem_addr,
  input  logic [NPORTS*DATA_W-1:0]   mem_wdata,
  input  logic [NPORTS*MASK_W-1:0]   mem_wmask,
  input  logic [NPORTS-1:0]          mem_wstrobe,
  input  logic [NPORTS-1:0]          mem_rstrobe,
  output logic [NPORTS*DATA_W-1:0]   mem_rdata,
  output logic [NPORTS-1:0]          mem_done,
  output logic [NPORTS-1:0]          active
);

  localparam int unsigned IDX_W = idx_width(SIZE);
  localparam logic [32:0] SPAN  = 33'(SIZE * 4);

  logic [DATA_W-1:0] mem [SIZE];

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] grant_c;
  logic [NPORTS-1:0] outstanding;
  logic [IDX_W-1:0]  idx [NPORTS];

  logic              g_any;
  logic              g_wr;
  logic [PID_W-1:0]  g_pid;
  logic [IDX_W-1:0]  g_idx;
  logic [DATA_W-1:0] g_wdata;
  logic [MASK_W-1:0] g_wmask;

  rd_stage_t launch;
  rd_stage_t tail;

  // Per-port address decode and request qualification.
  always_comb begin
    for (int p = 0; p < int'(NPORTS); p++) begin
      active[p] = addr_hit(mem_addr[p*DATA_W +: DATA_W], BASE_ADDR, SPAN);
      req[p]    = (mem_rstrobe[p] | mem_wstrobe[p]) & active[p];
      idx[p]    = IDX_W'((mem_addr[p*DATA_W +: DATA_W] - BASE_ADDR) >> 2);
    end
  end

  // A port with a transaction in flight (including its done cycle) cannot be re-granted.
  assign eligible = req & ~outstanding & {NPORTS{rst_n}};

  rr_arbiter #(.N(NPORTS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (eligible),
    .en      (1'b1),
    .grant_c (grant_c)
  );

  // Steer the granted port's request onto the single storage port.
  always_comb begin
    g_any   = 1'b0;
    g_wr    = 1'b0;
    g_pid   = '0;
    g_idx   = '0;
    g_wdata = '0;
    g_wmask = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (grant_c[p]) begin
        g_any   = 1'b1;
        g_wr    = mem_wstrobe[p];
        g_pid   = PID_W'(p);
        g_idx   = idx[p];
        g_wdata = mem_wdata[p*DATA_W +: DATA_W];
        g_wmask = mem_wmask[p*MASK_W +: MASK_W];
      end
    end
  end

  // Byte-lane write into storage at the acceptance edge.
  always_ff @(posedge clk) begin
    if (g_any && g_wr) begin
      for (int b = 0; b < int'(MASK_W); b++) begin
        if (g_wmask[b]) begin
          mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
        end
      end
    end
  end

  // First read stage: the word as it stands in the acceptance cycle.
  always_comb begin
    launch       = '0;
    launch.valid = g_any & ~g_wr;
    launch.pid   = g_pid;
    launch.data  = mem[g_idx];
  end

  // Extra read stages; the output register forms the last one.
  if (READ_LATENCY == 1) begin : g_lat1
    assign tail = launch;
  end else begin : g_pipe
    rd_stage_t pipe [READ_LATENCY-1];

    // Shift read results toward the outputs; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < int'(READ_LATENCY) - 1; k++) begin
          pipe[k] <= '0;
        end
      end else begin
        pipe[0] <= launch;
        for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
          pipe[k] <= pipe[k-1];
        end
      end
    end

    assign tail = pipe[READ_LATENCY-2];
  end

  // Completion pulses, held read data and per-port outstanding tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_done    <= '0;
      mem_rdata   <= '0;
      outstanding <= '0;
    end else begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        mem_done[p] <= (grant_c[p] & g_wr) | (tail.valid && (tail.pid == PID_W'(p)));
        if (tail.valid && (tail.pid == PID_W'(p))) begin
          mem_rdata[p*DATA_W +: DATA_W] <= tail.data;
        end
        outstanding[p] <= grant_c[p] | (outstanding[p] & ~mem_done[p]);
      end
    end
  end

endmodule

// File: tb/tb_memory_arb.sv
// Randomised scoreboard bench for memory_arb (2 ports, 3-cycle reads, base 0x1000).
module tb_memory_arb;

  localparam int unsigned NP   = 2;
  localparam int unsigned SZ   = 256;
  localparam int          LAT  = 3;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] p_addr  [NP];
  logic [31:0] p_wdata [NP];
  logic [3:0]  p_wmask [NP];
  logic        p_wr    [NP];
  logic        p_rd    [NP];

  logic [NP*32-1:0] mem_addr;
  logic [NP*32-1:0] mem_wdata;
  logic [NP*4-1:0]  mem_wmask;
  logic [NP-1:0]    mem_wstrobe;
  logic [NP-1:0]    mem_rstrobe;
  logic [NP*32-1:0] mem_rdata;
  logic [NP-1:0]    mem_done;
  logic [NP-1:0]    active;

  for (genvar g = 0; g < int'(NP); g++) begin : g_drv
    assign mem_addr[g*32 +: 32] = p_addr[g];
    assign mem_wdata[g*32 +: 32] = p_wdata[g];
    assign mem_wmask[g*4 +: 4]  = p_wmask[g];
    assign mem_wstrobe[g]       = p_wr[g];
    assign mem_rstrobe[g]       = p_rd[g];
  end

  memory_arb #(
    .SIZE(SZ), .BASE_ADDR(BASE), .NPORTS(NP), .READ_LATENCY(LAT), .INIT_F("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .active(active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          issue;
    int          lat_lo;
    int          lat_hi;
  } exp_t;

  exp_t        sb [NP][$];
  logic [31:0] ref_mem [SZ];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    check(name, act === req, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation of its port.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < int'(NP); p++) begin
        if (mem_done[p]) begin
          if (sb[p].size() == 0) begin
            check("spurious_done", 1'b0, 32'(p), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            int   lat;
            e   = sb[p].pop_front();
            lat = cyc - e.issue;
            check("done_latency", (lat >= e.lat_lo) && (lat <= e.lat_hi), 32'(lat), 32'(e.lat_lo));
            if (!e.wr) check_eq("rdata", mem_rdata[p*32 +: 32], e.data);
          end
        end
      end
    end
  end

  // One master transaction, issued at a falling edge; the model is updated at issue.
  task automatic xfer(input int p, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] m, input int lo, input int hi);
    exp_t e;
    int   w;
    bit   got;
    w        = int'((addr - BASE) >> 2);
    e.wr     = wr;
    e.issue  = cyc;
    e.lat_lo = lo;
    e.lat_hi = hi;
    e.data   = '0;
    if (wr) begin
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[w][b*8 +: 8] = wd[b*8 +: 8];
    end else begin
      e.data = ref_mem[w];
    end
    sb[p].push_back(e);
    p_addr[p]  = addr;
    p_wdata[p] = wd;
    p_wmask[p] = m;
    p_wr[p]    = wr;
    p_rd[p]    = !wr;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = mem_done[p];
    end
    p_wr[p] = 1'b0;
    p_rd[p] = 1'b0;
    if (!got) begin
      check("done_timeout", 1'b0, 32'(p), 32'(lo));
      sb[p].delete();
    end
    @(negedge clk);
  endtask

  task automatic rand_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int          w;
      logic [31:0] a;
      w = 64 + p * 16 + int'($urandom_range(0, 15));
      a = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) xfer(p, 1'b1, a, $urandom, 4'($urandom), 1, 2);
      else xfer(p, 1'b0, a, 32'h0, 4'h0, LAT, LAT + 1);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < int'(NP); p++) begin
      p_addr[p] = BASE; p_wdata[p] = '0; p_wmask[p] = '0; p_wr[p] = 1'b0; p_rd[p] = 1'b0;
    end
    for (int i = 0; i < int'(SZ); i++) ref_mem[i] = '0;

    // Reset values
    idle_cycles(3);
    check_eq("reset_done", 32'(mem_done), 32'h0);
    check_eq("reset_rdata0", mem_rdata[31:0], 32'h0);
    check_eq("reset_rdata1", mem_rdata[63:32], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Seed two words, then contend: pointer is back at 0 after the port-1 write
    xfer(0, 1'b1, BASE + 32'h40, 32'h0102_0304, 4'hF, 1, 1);
    xfer(1, 1'b1, BASE + 32'h44, 32'hA0B0_C0D0, 4'hF, 1, 1);
    fork
      xfer(0, 1'b0, BASE + 32'h40, 32'h0, 4'h0, LAT, LAT);
      xfer(1, 1'b0, BASE + 32'h44, 32'h0, 4'h0, LAT + 1, LAT + 1);
    join
    // After a lone port-0 grant, port 1 leads the next contention
    xfer(0, 1'b1, BASE + 32'h48, 32'h5555_AAAA, 4'hF, 1, 1);
    fork
      xfer(0, 1'b0, BASE + 32'h48, 32'h0, 4'h0, LAT + 1, LAT + 1);
      xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, LAT, LAT);
    join

    // Single-port write then read
    xfer(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 1);
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, LAT, LAT);
    check_eq("wr_rd_deadbeef", mem_rdata[31:0], 32'hDEAD_BEEF);

    // Byte-masked write
    xfer(0, 1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, 1, 1);
    xfer(0, 1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1, 1);
    xfer(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, LAT, LAT);
    check_eq("byte_mask", mem_rdata[31:0], 32'h11BB_33DD);

    // Read-after-write across ports
    xfer(0, 1'b1, BASE + 32'h30, 32'hCAFE_F00D, 4'hF, 1, 1);
    xfer(1, 1'b0, BASE + 32'h30, 32'h0, 4'h0, LAT, LAT);
    check_eq("cross_port_raw", mem_rdata[63:32], 32'hCAFE_F00D);

    // Decode boundaries: out-of-window requests are ignored and leave memory alone
    xfer(0, 1'b1, BASE, 32'h0BAD_CAFE, 4'hF, 1, 1);
    p_addr[0] = 32'h0000_0FFC; p_rd[0] = 1'b1;
    #1 check_eq("active_below", 32'(active[0]), 32'h0);
    idle_cycles(6);
    p_addr[0] = 32'h0000_1400; p_wdata[0] = 32'hFFFF_0000; p_wmask[0] = 4'hF;
    p_rd[0] = 1'b0; p_wr[0] = 1'b1;
    #1 check_eq("active_above", 32'(active[0]), 32'h0);
    idle_cycles(6);
    p_wr[0] = 1'b0;
    p_addr[1] = 32'h0000_13FC;
    #1 check_eq("active_top", 32'(active[1]), 32'h1);
    @(negedge clk);
    xfer(0, 1'b0, BASE, 32'h0, 4'h0, LAT, LAT);
    check_eq("decode_mem_unchanged", mem_rdata[31:0], 32'h0BAD_CAFE);
    xfer(1, 1'b1, 32'h0000_13FC, 32'h7E57_0FF0, 4'hF, 1, 1);
    xfer(1, 1'b0, 32'h0000_13FC, 32'h0, 4'h0, LAT, LAT);

    // Reset one cycle after a read is accepted: no done, rdata cleared, memory kept
    p_addr[0] = BASE + 32'h10; p_rd[0] = 1'b1;
    idle_cycles(2);
    rst_n = 1'b0;
    p_rd[0] = 1'b0;
    idle_cycles(2);
    check_eq("rst_mid_done", 32'(mem_done), 32'h0);
    check_eq("rst_mid_rdata", mem_rdata[31:0], 32'h0);
    rst_n = 1'b1;
    idle_cycles(LAT + 3);
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, LAT, LAT);
    check_eq("post_reset_read", mem_rdata[31:0], 32'hDEAD_BEEF);

    // Randomised traffic on disjoint per-port regions
    fork
      for (int w = 0; w < 16; w++) xfer(0, 1'b1, BASE + 32'((64 + w) * 4), $urandom, 4'hF, 1, 2);
      for (int w = 0; w < 16; w++) xfer(1, 1'b1, BASE + 32'((80 + w) * 4), $urandom, 4'hF, 1, 2);
    join
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join

    idle_cycles(LAT + 4);
    check_eq("sb0_drained", 32'(sb[0].size()), 32'h0);
    check_eq("sb1_drained", 32'(sb[1].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
